// File: rtl/mix_chan_sched.sv
// Round-robin scheduler sharing one NCO/mixer between NRX channels: per-channel phase
// accumulators, shadowed frequency config applied at frame end, and a tag pipe re-aligning results.
module mix_chan_sched #(
    parameter int unsigned NRX    = 4,
    parameter int unsigned MIXLAT = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [2:0]         cfg_chan_i,
    input  logic [31:0]        cfg_freq_i,
    input  logic               cfg_clr_i,
    output logic               cfg_err_o,
    output logic [31:0]        phi_o,
    output logic               phi_valid_o,
    output logic [2:0]         phi_chan_o,
    output logic               frame_start_o,
    input  logic signed [17:0] mix_i_i,
    input  logic signed [17:0] mix_q_i,
    output logic               out_valid_o,
    output logic [2:0]         out_chan_o,
    output logic signed [17:0] out_i_o,
    output logic signed [17:0] out_q_o
);
    localparam int unsigned MaxCh = 8;

    logic [31:0] acc_q     [MaxCh];
    logic [31:0] freq_q    [MaxCh];
    logic [31:0] sh_freq_q [MaxCh];
    logic [MaxCh-1:0] sh_clr_q, pend_q;
    logic [2:0]  slot_q;
    logic [31:0] phi_q;
    logic        phi_valid_q, frame_start_q, cfg_err_q;
    logic [2:0]  phi_chan_q;
    logic [3:0]  tag_q [MIXLAT];
    logic        out_valid_q;
    logic [2:0]  out_chan_q;
    logic signed [17:0] out_i_q, out_q_q;

    logic cfg_in_range, cfg_accept, accept_ok, accept_bad, slot_last, apply;

    always_comb begin
        cfg_in_range = {29'b0, cfg_chan_i} < NRX;
        cfg_ready_o  = !cfg_in_range || !pend_q[cfg_chan_i];
        cfg_accept   = cfg_valid_i && cfg_ready_o;
        accept_ok    = cfg_accept && cfg_in_range;
        accept_bad   = cfg_accept && !cfg_in_range;
        slot_last    = slot_q == 3'(NRX - 1);
        // Running: apply at the frame's last issue; idle: apply as soon as anything is pending.
        apply        = run_i ? slot_last : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= '0;
            phi_q         <= '0;
            phi_valid_q   <= 1'b0;
            phi_chan_q    <= '0;
            frame_start_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            sh_clr_q      <= '0;
            pend_q        <= '0;
            for (int i = 0; i < int'(MaxCh); i++) begin
                acc_q[i]     <= '0;
                freq_q[i]    <= '0;
                sh_freq_q[i] <= '0;
            end
        end else begin
            cfg_err_q <= accept_bad;
            if (run_i) begin
                phi_q         <= acc_q[slot_q];
                phi_chan_q    <= slot_q;
                phi_valid_q   <= 1'b1;
                frame_start_q <= slot_q == 3'd0;
                slot_q        <= slot_last ? 3'd0 : slot_q + 3'd1;
            end else begin
                phi_valid_q   <= 1'b0;
                frame_start_q <= 1'b0;
                slot_q        <= '0;
            end
            for (int i = 0; i < int'(NRX); i++) begin
                if (run_i && slot_q == 3'(i)) begin
                    acc_q[i] <= acc_q[i] + freq_q[i];
                end
                // A clear on apply overrides the same-clock accumulator update.
                if (apply && pend_q[i]) begin
                    freq_q[i] <= sh_freq_q[i];
                    if (sh_clr_q[i]) begin
                        acc_q[i] <= '0;
                    end
                    pend_q[i] <= 1'b0;
                end
                if (accept_ok && cfg_chan_i == 3'(i)) begin
                    sh_freq_q[i] <= cfg_freq_i;
                    sh_clr_q[i]  <= cfg_clr_i;
                    pend_q[i]    <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(MIXLAT); k++) begin
                tag_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            tag_q[0] <= {phi_valid_q, phi_chan_q};
            for (int k = 1; k < int'(MIXLAT); k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            out_valid_q <= tag_q[MIXLAT-1][3];
            if (tag_q[MIXLAT-1][3]) begin
                out_chan_q <= tag_q[MIXLAT-1][2:0];
                out_i_q    <= mix_i_i;
                out_q_q    <= mix_q_i;
            end
        end
    end

    assign phi_o         = phi_q;
    assign phi_valid_o   = phi_valid_q;
    assign phi_chan_o    = phi_chan_q;
    assign frame_start_o = frame_start_q;
    assign cfg_err_o     = cfg_err_q;
    assign out_valid_o   = out_valid_q;
    assign out_chan_o    = out_chan_q;
    assign out_i_o       = out_i_q;
    assign out_q_o       = out_q_q;

endmodule

// File: tb/tb_mix_chan_sched.sv
// Bench for mix_chan_sched: directed frames push expected issues/results into queues,
// a negedge monitor pops and compares; a behavioural mixer returns chan-derived I/Q.
module tb_mix_chan_sched;
    localparam int NRX    = 4;
    localparam int MIXLAT = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               run_i = 1'b0;
    logic               cfg_valid_i = 1'b0;
    logic               cfg_ready_o;
    logic [2:0]         cfg_chan_i = '0;
    logic [31:0]        cfg_freq_i = '0;
    logic               cfg_clr_i = 1'b0;
    logic               cfg_err_o;
    logic [31:0]        phi_o;
    logic               phi_valid_o;
    logic [2:0]         phi_chan_o;
    logic               frame_start_o;
    logic signed [17:0] mix_i_i = '0;
    logic signed [17:0] mix_q_i = '0;
    logic               out_valid_o;
    logic [2:0]         out_chan_o;
    logic signed [17:0] out_i_o;
    logic signed [17:0] out_q_o;

    mix_chan_sched #(.NRX(NRX), .MIXLAT(MIXLAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_freq_i   (cfg_freq_i),
        .cfg_clr_i    (cfg_clr_i),
        .cfg_err_o    (cfg_err_o),
        .phi_o        (phi_o),
        .phi_valid_o  (phi_valid_o),
        .phi_chan_o   (phi_chan_o),
        .frame_start_o(frame_start_o),
        .mix_i_i      (mix_i_i),
        .mix_q_i      (mix_q_i),
        .out_valid_o  (out_valid_o),
        .out_chan_o   (out_chan_o),
        .out_i_o      (out_i_o),
        .out_q_o      (out_q_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] ph;
    } exp_t;

    exp_t       exp_phi[$];
    logic [2:0] exp_out[$];
    int         lat_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [2:0] mix_sh [MIXLAT+1] = '{default: '0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Mixer model: result for the phi seen MIXLAT cycles ago.
    always @(negedge clk) begin
        int c;
        for (int k = MIXLAT; k > 0; k--) mix_sh[k] = mix_sh[k-1];
        mix_sh[0] = phi_chan_o;
        c = int'(mix_sh[MIXLAT]);
        mix_i_i = 18'(c * 100);
        mix_q_i = 18'(c * 7 - 20);
    end

    always @(negedge clk) begin
        exp_t e;
        logic [2:0] ec;
        logic signed [17:0] ei, eq;
        int t0;
        if (phi_valid_o) begin
            if (exp_phi.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL phi_unexpected: got chan %0d phi %0h, expected no issue",
                         phi_chan_o, phi_o);
            end else begin
                e = exp_phi.pop_front();
                chk("phi_chan", 64'(phi_chan_o), 64'(e.ch));
                chk("phi", 64'(phi_o), 64'(e.ph));
                chk("frame_start", 64'(frame_start_o), 64'(e.ch == 3'd0));
                lat_q.push_back(cyc);
            end
        end else begin
            chk("frame_start_idle", 64'(frame_start_o), 64'(0));
        end
        if (out_valid_o) begin
            if (exp_out.size() == 0 || lat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got chan %0d, expected no result", out_chan_o);
            end else begin
                ec = exp_out.pop_front();
                t0 = lat_q.pop_front();
                ei = 18'(int'(ec) * 100);
                eq = 18'(int'(ec) * 7 - 20);
                chk("out_chan", 64'(out_chan_o), 64'(ec));
                chk("out_i", 64'(out_i_o), 64'(ei));
                chk("out_q", 64'(out_q_o), 64'(eq));
                chk("out_latency", 64'(cyc - t0), 64'(MIXLAT + 1));
            end
        end
    end

    task automatic slot(input int ch, input logic [31:0] ph);
        run_i = 1'b1;
        exp_phi.push_back('{ch: 3'(ch), ph: ph});
        exp_out.push_back(3'(ch));
        @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3);
        slot(0, p0);
        slot(1, p1);
        slot(2, p2);
        slot(3, p3);
    endtask

    task automatic idle(input int n);
        run_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phi"}, 64'(phi_o), 64'(0));
        chk({tag, "_phi_valid"}, 64'(phi_valid_o), 64'(0));
        chk({tag, "_phi_chan"}, 64'(phi_chan_o), 64'(0));
        chk({tag, "_frame_start"}, 64'(frame_start_o), 64'(0));
        chk({tag, "_cfg_err"}, 64'(cfg_err_o), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, "_out_chan"}, 64'(out_chan_o), 64'(0));
        chk({tag, "_out_i"}, 64'(out_i_o), 64'(0));
        chk({tag, "_out_q"}, 64'(out_q_o), 64'(0));
        chk({tag, "_cfg_ready"}, 64'(cfg_ready_o), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // No config: all phases zero, channels cycle, frame_start on slot 0.
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        idle(10);

        // Idle config of ch1, applied on the clock after acceptance.
        cfg_valid_i = 1'b1; cfg_chan_i = 3'd1; cfg_freq_i = 32'h1000; cfg_clr_i = 1'b0;
        #1 chk("cfg_ready_idle", 64'(cfg_ready_o), 64'(1));
        @(negedge clk);
        cfg_valid_i = 1'b0;
        #1 chk("cfg_ready_idle_pending", 64'(cfg_ready_o), 64'(0));
        @(negedge clk);
        #1 chk("cfg_ready_idle_applied", 64'(cfg_ready_o), 64'(1));
        frame(0, 0, 0, 0);
        frame(0, 32'h1000, 0, 0);
        frame(0, 32'h2000, 0, 0);
        idle(8);

        // Accumulator wrap on ch0.
        cfg_valid_i = 1'b1; cfg_chan_i = 3'd0; cfg_freq_i = 32'hC000_0000;
        @(negedge clk);
        cfg_valid_i = 1'b0;
        @(negedge clk);
        frame(32'h0,         32'h3000, 0, 0);
        frame(32'hC000_0000, 32'h4000, 0, 0);
        frame(32'h8000_0000, 32'h5000, 0, 0);
        frame(32'h4000_0000, 32'h6000, 0, 0);
        frame(32'h0,         32'h7000, 0, 0);
        idle(8);

        // Back-to-back writes to ch2 while running, then a write to a bad channel.
        cfg_valid_i = 1'b1; cfg_chan_i = 3'd2; cfg_freq_i = 32'h10; cfg_clr_i = 1'b0;
        #1 chk("cfg_ready_run_first", 64'(cfg_ready_o), 64'(1));
        slot(0, 32'hC000_0000);
        cfg_freq_i = 32'h20; cfg_clr_i = 1'b1;
        #1 chk("cfg_ready_pending_s1", 64'(cfg_ready_o), 64'(0));
        slot(1, 32'h8000);
        #1 chk("cfg_ready_pending_s2", 64'(cfg_ready_o), 64'(0));
        slot(2, 0);
        #1 chk("cfg_ready_pending_s3", 64'(cfg_ready_o), 64'(0));
        slot(3, 0);
        #1 chk("cfg_ready_after_apply", 64'(cfg_ready_o), 64'(1));
        slot(0, 32'h8000_0000);
        cfg_chan_i = 3'd6; cfg_freq_i = 32'hDEAD; cfg_clr_i = 1'b1;
        #1 chk("cfg_ready_badchan", 64'(cfg_ready_o), 64'(1));
        chk("cfg_err_before", 64'(cfg_err_o), 64'(0));
        slot(1, 32'h9000);
        cfg_valid_i = 1'b0;
        #1 chk("cfg_err_pulse", 64'(cfg_err_o), 64'(1));
        slot(2, 0);
        #1 chk("cfg_err_cleared", 64'(cfg_err_o), 64'(0));
        slot(3, 0);
        frame(32'h4000_0000, 32'hA000, 32'h0, 0);
        frame(32'h0,         32'hB000, 32'h20, 0);

        // Drop run after slot 1, restart three clocks later at slot 0.
        slot(0, 32'hC000_0000);
        slot(1, 32'hC000);
        idle(3);
        frame(32'h8000_0000, 32'hD000, 32'h40, 0);
        idle(10);

        // Reset pulse mid-frame discards in-flight tags and all state.
        slot(0, 32'h4000_0000);
        slot(1, 32'hE000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        run_i = 1'b0;
        exp_out.delete();
        lat_q.delete();
        #1 chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(0, 0, 0, 0);
        idle(12);

        chk("phi_queue_drained", 64'(exp_phi.size()), 64'(0));
        chk("out_queue_drained", 64'(exp_out.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
